// File: rtl/mips_pkg.sv
// Shared constants for the 5-stage MIPS pipeline.
//   NOP_INSTR     all-zero word (sll $0,$0,0), used for bubbles and flushes
//   INSTR_W/PC_W  instruction and program-counter widths
//   OPCODE_*      position of the major opcode field
package mips_pkg;

   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned PC_W      = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 26;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register.
//   clk, rst        rising-edge clock, synchronous active-high reset
//   load            capture d_* when high, hold otherwise
//   flush           kill the slot (pc 0, NOP, invalid); wins over hold
//   d_pc/d_instr/d_valid   incoming PC+4, instruction word, valid flag
//   q_pc/q_instr/q_valid   registered values to the ID stage
// Reset produces the same value as a flush.
module if_id_register
   import mips_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               flush,
   input  logic [PC_W-1:0]    d_pc,
   input  logic [INSTR_W-1:0] d_instr,
   input  logic               d_valid,
   output logic [PC_W-1:0]    q_pc,
   output logic [INSTR_W-1:0] q_instr,
   output logic               q_valid
);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         q_pc    <= '0;
         q_instr <= NOP_INSTR;
         q_valid <= 1'b0;
      end else if (load) begin
         q_pc    <= d_pc;
         q_instr <= d_instr;
         q_valid <= d_valid;
      end
   end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, addresses the external combinational ROM and
// captures the returned word plus PC+4 into the IF/ID register.
//   clk, rst          rising-edge clock, synchronous active-high reset
//   freeze            hazard stall: hold PC and IF/ID
//   branch_taken      redirect to branch_addr and flush IF/ID (beats freeze)
//   branch_addr       redirect target, low two bits dropped
//   rom_instruction   ROM word at pc_out
//   pc_out            current fetch PC (registered)
//   if_id_pc/instr/valid   IF/ID register outputs to decode
module instruction_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC  = 32'd0,
   parameter int unsigned     ROM_BYTES = 48,
   parameter int unsigned     PC_STEP   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_addr,
   input  logic [INSTR_W-1:0] rom_instruction,
   output logic [PC_W-1:0]    pc_out,
   output logic [PC_W-1:0]    if_id_pc,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic               if_id_valid
);

   logic [PC_W-1:0]    pc_q;
   logic [PC_W-1:0]    pc_d;
   logic [PC_W-1:0]    pc_plus;
   logic               in_range;
   logic [INSTR_W-1:0] fetched;

   assign pc_plus  = pc_q + PC_W'(PC_STEP);
   assign in_range = (pc_q < PC_W'(ROM_BYTES));
   // Out-of-range ROM addresses float, so never let that data into IF/ID.
   assign fetched  = in_range ? rom_instruction : NOP_INSTR;

   always_comb begin
      pc_d = pc_q;
      if (branch_taken) begin
         pc_d = {branch_addr[PC_W-1:2], 2'b00};
      end else if (!freeze) begin
         pc_d = pc_plus;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_out = pc_q;

   // Branch flush overrides freeze: the held ID slot is the wrong-path one.
   if_id_register u_if_id (
      .clk     (clk),
      .rst     (rst),
      .load    (~freeze),
      .flush   (branch_taken),
      .d_pc    (pc_plus),
      .d_instr (fetched),
      .d_valid (in_range),
      .q_pc    (if_id_pc),
      .q_instr (if_id_instr),
      .q_valid (if_id_valid)
   );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [31:0] rom_instruction;
   logic [31:0] pc_out;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;

   int total = 0;
   int bad   = 0;

   logic [31:0] rom [12];

   always #5 clk = ~clk;

   // Program ROM; beyond the program a junk pattern stands in for floating data.
   always_comb begin
      rom_instruction = 32'hDEAD_BEEF;
      if (pc_out < 32'd48) rom_instruction = rom[pc_out[5:2]];
   end

   instruction_fetch_stage dut (
      .clk             (clk),
      .rst             (rst),
      .freeze          (freeze),
      .branch_taken    (branch_taken),
      .branch_addr     (branch_addr),
      .rom_instruction (rom_instruction),
      .pc_out          (pc_out),
      .if_id_pc        (if_id_pc),
      .if_id_instr     (if_id_instr),
      .if_id_valid     (if_id_valid)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_all(input string tag, input logic [31:0] pc,
                             input logic [31:0] ipc, input logic [31:0] instr,
                             input logic valid);
      chk({tag, ".pc_out"},      pc_out,             pc);
      chk({tag, ".if_id_pc"},    if_id_pc,           ipc);
      chk({tag, ".if_id_instr"}, if_id_instr,        instr);
      chk({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, valid});
   endtask

   initial begin
      rom[0]  = 32'h8001060A; rom[1]  = 32'h20020005; rom[2]  = 32'h20030007;
      rom[3]  = 32'h00432020; rom[4]  = 32'hAC040000; rom[5]  = 32'h8C050000;
      rom[6]  = 32'h10A00002; rom[7]  = 32'h00000000; rom[8]  = 32'h20060001;
      rom[9]  = 32'h80010400; rom[10] = 32'h00C63020; rom[11] = 32'h08000000;

      rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
      step(); step();
      expect_all("reset", 32'd0, 32'd0, 32'd0, 1'b0);

      // Sequential fetch
      rst = 1'b0;
      step(); expect_all("seq0", 32'd4,  32'd4,  32'h8001060A, 1'b1);
      step(); expect_all("seq1", 32'd8,  32'd8,  32'h20020005, 1'b1);
      step(); expect_all("seq2", 32'd12, 32'd12, 32'h20030007, 1'b1);
      step(); expect_all("seq3", 32'd16, 32'd16, 32'h00432020, 1'b1);

      // Freeze two cycles at pc 16
      freeze = 1'b1;
      step(); expect_all("frz0", 32'd16, 32'd16, 32'h00432020, 1'b1);
      step(); expect_all("frz1", 32'd16, 32'd16, 32'h00432020, 1'b1);
      freeze = 1'b0;
      step(); expect_all("frz_rel", 32'd20, 32'd20, 32'hAC040000, 1'b1);

      // Branch to 36
      branch_taken = 1'b1; branch_addr = 32'd36;
      step(); expect_all("br36", 32'd36, 32'd0, 32'd0, 1'b0);
      branch_taken = 1'b0;
      step(); expect_all("br36_tgt", 32'd40, 32'd40, 32'h80010400, 1'b1);

      // Branch with freeze, then back-to-back misaligned target
      branch_taken = 1'b1; freeze = 1'b1; branch_addr = 32'd8;
      step(); expect_all("br_frz", 32'd8, 32'd0, 32'd0, 1'b0);
      branch_addr = 32'd10;
      step(); expect_all("br_misal", 32'd8, 32'd0, 32'd0, 1'b0);
      branch_taken = 1'b0; freeze = 1'b0;
      step(); expect_all("br8_tgt", 32'd12, 32'd12, 32'h20030007, 1'b1);

      // End of program and beyond
      branch_taken = 1'b1; branch_addr = 32'd40;
      step(); expect_all("br40", 32'd40, 32'd0, 32'd0, 1'b0);
      branch_taken = 1'b0;
      step(); expect_all("pc40", 32'd44, 32'd44, 32'h00C63020, 1'b1);
      step(); expect_all("pc44", 32'd48, 32'd48, 32'h08000000, 1'b1);
      step(); expect_all("pc48", 32'd52, 32'd52, 32'd0, 1'b0);
      step(); expect_all("pc52", 32'd56, 32'd56, 32'd0, 1'b0);

      // Reset beats branch and freeze, then restart
      rst = 1'b1; branch_taken = 1'b1; freeze = 1'b1; branch_addr = 32'd20;
      step(); expect_all("rst_mid", 32'd0, 32'd0, 32'd0, 1'b0);
      rst = 1'b0; branch_taken = 1'b0; freeze = 1'b0;
      step(); expect_all("rs0", 32'd4, 32'd4, 32'h8001060A, 1'b1);
      step(); expect_all("rs1", 32'd8, 32'd8, 32'h20020005, 1'b1);
      step(); expect_all("rs2", 32'd12, 32'd12, 32'h20030007, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
